// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
// Shared geometry and types for the decode-stage register file slice.
//   DATA_W   : register width in bits
//   NREG     : number of architectural registers, AW = $clog2(NREG)
//   NRD      : number of combinational read ports
//   LINK_REG : destination used by JAL writes (alu_wr_link = 1)
//   MAX_PEND : maximum outstanding loads, PW = $clog2(MAX_PEND+1)
//   wb_src_e : which source owns the single array write port this cycle
//   link_dest: resolves the ALU/JAL destination register
// Optional feature macro used by the design: REGFILE_BYPASS_EN
// ----------------------------------------------------------------------------
package regfile_pkg;

   localparam int DATA_W   = 32;
   localparam int NREG     = 32;
   localparam int AW       = $clog2(NREG);
   localparam int NRD      = 2;
   localparam int LINK_REG = 31;
   localparam int MAX_PEND = 4;
   localparam int PW       = $clog2(MAX_PEND + 1);

   typedef enum logic [1:0] {
      WB_NONE = 2'd0,
      WB_ALU  = 2'd1,
      WB_LD   = 2'd2
   } wb_src_e;

   // JAL writes always target the link register; the requested address is ignored.
   function automatic logic [AW-1:0] link_dest(input logic link, input logic [AW-1:0] addr);
      return link ? AW'(LINK_REG) : addr;
   endfunction

endpackage

// File: rtl/regfile_bank_if.sv
// ----------------------------------------------------------------------------
// regfile_bank_if
// Bundles the register-file read ports, the ALU/JAL write port, the load
// issue/response ports and the scoreboard status outputs.
//   master : decode / execute side (drives addresses, requests, load data)
//   slave  : regfile_bank (returns read data, ready flags, status)
// Signals:
//   rd_addr  / rd_data / rd_busy            : NRD packed read ports
//   alu_wr_valid/ready/addr/link/data       : ALU and JAL write-back
//   ld_iss_valid/ready/addr                 : load destination reservation
//   ld_rsp_valid/addr/data                  : load data return, never stalled
//   pend_cnt / err                          : outstanding loads, sticky error
// ----------------------------------------------------------------------------
interface regfile_bank_if;
   import regfile_pkg::*;

   logic [NRD*AW-1:0]     rd_addr;
   logic [NRD*DATA_W-1:0] rd_data;
   logic [NRD-1:0]        rd_busy;

   logic                  alu_wr_valid;
   logic                  alu_wr_ready;
   logic [AW-1:0]         alu_wr_addr;
   logic                  alu_wr_link;
   logic [DATA_W-1:0]     alu_wr_data;

   logic                  ld_iss_valid;
   logic                  ld_iss_ready;
   logic [AW-1:0]         ld_iss_addr;

   logic                  ld_rsp_valid;
   logic [AW-1:0]         ld_rsp_addr;
   logic [DATA_W-1:0]     ld_rsp_data;

   logic [PW-1:0]         pend_cnt;
   logic                  err;

   modport master (
      output rd_addr,
      input  rd_data, rd_busy,
      output alu_wr_valid, alu_wr_addr, alu_wr_link, alu_wr_data,
      input  alu_wr_ready,
      output ld_iss_valid, ld_iss_addr,
      input  ld_iss_ready,
      output ld_rsp_valid, ld_rsp_addr, ld_rsp_data,
      input  pend_cnt, err
   );

   modport slave (
      input  rd_addr,
      output rd_data, rd_busy,
      input  alu_wr_valid, alu_wr_addr, alu_wr_link, alu_wr_data,
      output alu_wr_ready,
      input  ld_iss_valid, ld_iss_addr,
      output ld_iss_ready,
      input  ld_rsp_valid, ld_rsp_addr, ld_rsp_data,
      output pend_cnt, err
   );

endinterface

// File: rtl/regfile_scoreboard.sv
// ----------------------------------------------------------------------------
// regfile_scoreboard
// Tracks which registers have a load outstanding so decode can stall on
// RAW/WAW hazards, counts outstanding loads and flags stray responses.
// Ports:
//   clock, reset  : clock, synchronous active-low reset
//   iss_valid_i   : load issue request
//   iss_addr_i    : load destination register
//   iss_ready_o   : reservation accepted this cycle
//   rsp_valid_i   : load response present
//   rsp_addr_i    : load response destination
//   rsp_hit_o     : response matches a pending register (it will be written)
//   pend_o        : per-register pending bits (registered)
//   pend_cnt_o    : number of outstanding loads
//   err_o         : sticky, response arrived for a non-pending register
// ----------------------------------------------------------------------------
module regfile_scoreboard
   import regfile_pkg::*;
(
   input  logic            clock,
   input  logic            reset,
   input  logic            iss_valid_i,
   input  logic [AW-1:0]   iss_addr_i,
   output logic            iss_ready_o,
   input  logic            rsp_valid_i,
   input  logic [AW-1:0]   rsp_addr_i,
   output logic            rsp_hit_o,
   output logic [NREG-1:0] pend_o,
   output logic [PW-1:0]   pend_cnt_o,
   output logic            err_o
);

   logic [NREG-1:0] pend_q, pend_d;
   logic [PW-1:0]   cnt_q, cnt_d;
   logic            err_q, err_d;

   logic            rsp_hit;
   logic            rsp_bad;
   logic            iss_blocked;
   logic            iss_ready;
   logic            iss_set;
   logic [PW-1:0]   cnt_after_rsp;

   // Next-state for the scoreboard. A response retiring a load frees its slot
   // and its pending bit within the same cycle, so an issue can reuse both
   // immediately. Register 0 never becomes pending: an issue to it is accepted
   // but leaves the bit and the count alone, and a response to it is simply
   // dropped without raising the error flag.
   always_comb begin
      rsp_hit       = rsp_valid_i && pend_q[rsp_addr_i];
      rsp_bad       = rsp_valid_i && !pend_q[rsp_addr_i] && (rsp_addr_i != '0);
      cnt_after_rsp = cnt_q - PW'(rsp_hit);
      iss_blocked   = pend_q[iss_addr_i] && !(rsp_hit && (rsp_addr_i == iss_addr_i));
      iss_ready     = (cnt_after_rsp < PW'(MAX_PEND)) && !iss_blocked;
      iss_set       = iss_valid_i && iss_ready && (iss_addr_i != '0);

      pend_d = pend_q;
      if (rsp_hit) begin
         pend_d[rsp_addr_i] = 1'b0;
      end
      // Applied after the clear so a same-register issue keeps the bit set.
      if (iss_set) begin
         pend_d[iss_addr_i] = 1'b1;
      end

      cnt_d = cnt_q + PW'(iss_set) - PW'(rsp_hit);
      err_d = err_q | rsp_bad;
   end

   // Scoreboard state register; reset abandons every outstanding load.
   always_ff @(posedge clock) begin
      if (!reset) begin
         pend_q <= '0;
         cnt_q  <= '0;
         err_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
         err_q  <= err_d;
      end
   end

   assign iss_ready_o = iss_ready;
   assign rsp_hit_o   = rsp_hit;
   assign pend_o      = pend_q;
   assign pend_cnt_o  = cnt_q;
   assign err_o       = err_q;

endmodule

// File: rtl/regfile_bank.sv
// ----------------------------------------------------------------------------
// regfile_bank
// Decode-stage register file: NRD combinational read ports and one write
// port shared by ALU/JAL write-back and load responses (loads win). A load
// scoreboard marks registers with outstanding loads so decode can stall.
// Ports:
//   clock : system clock, all state on posedge
//   reset : synchronous active-low reset
//   bus   : regfile_bank_if.slave
//             rd_addr/rd_data/rd_busy        read ports
//             alu_wr_valid/ready/addr/link/data  ALU and JAL write
//             ld_iss_valid/ready/addr        load reservation
//             ld_rsp_valid/addr/data         load return
//             pend_cnt/err                   scoreboard status
// Configuration macro: REGFILE_BYPASS_EN
//   defined   : reads of the register committed this cycle return the write
//               data, and rd_busy drops in the response cycle
//   undefined : reads return array contents only; rd_busy is the registered
//               pending bit
// ----------------------------------------------------------------------------
module regfile_bank
   import regfile_pkg::*;
(
   input logic           clock,
   input logic           reset,
   regfile_bank_if.slave bus
);

   logic [DATA_W-1:0]     regs_q [NREG];

   logic [NREG-1:0]       pend;
   logic [PW-1:0]         pend_cnt;
   logic                  err;
   logic                  rsp_hit;
   logic                  iss_ready;

   logic [AW-1:0]         alu_dest;
   logic                  alu_ready;
   logic                  alu_fire;

   wb_src_e               wb_src_d;
   logic [AW-1:0]         wb_addr_d;
   logic [DATA_W-1:0]     wb_data_d;

   logic [NRD*DATA_W-1:0] rd_data_c;
   logic [NRD-1:0]        rd_busy_c;

   regfile_scoreboard u_scoreboard (
      .clock       (clock),
      .reset       (reset),
      .iss_valid_i (bus.ld_iss_valid),
      .iss_addr_i  (bus.ld_iss_addr),
      .iss_ready_o (iss_ready),
      .rsp_valid_i (bus.ld_rsp_valid),
      .rsp_addr_i  (bus.ld_rsp_addr),
      .rsp_hit_o   (rsp_hit),
      .pend_o      (pend),
      .pend_cnt_o  (pend_cnt),
      .err_o       (err)
   );

   // ALU/JAL write handshake. Any load response on the bus takes the write
   // port, and a destination with a load in flight must wait so the older
   // load cannot overwrite the younger ALU result. The requester holds valid
   // until ready, so the write is never lost.
   always_comb begin
      alu_dest  = link_dest(bus.alu_wr_link, bus.alu_wr_addr);
      alu_ready = !bus.ld_rsp_valid && !pend[alu_dest];
      alu_fire  = bus.alu_wr_valid && alu_ready;
   end

   // Write arbiter: pick the single source that owns the array this cycle.
   // Stray load responses (not pending) are dropped by the scoreboard and do
   // not write.
   always_comb begin
      wb_src_d  = WB_NONE;
      wb_addr_d = '0;
      wb_data_d = '0;
      if (rsp_hit) begin
         wb_src_d  = WB_LD;
         wb_addr_d = bus.ld_rsp_addr;
         wb_data_d = bus.ld_rsp_data;
      end else if (alu_fire) begin
         wb_src_d  = WB_ALU;
         wb_addr_d = alu_dest;
         wb_data_d = bus.alu_wr_data;
      end
   end

   // Register array. Register 0 is cleared by reset and never written, which
   // is what makes it read as zero without a separate read-side mux.
   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int r = 0; r < NREG; r++) begin
            regs_q[r] <= '0;
         end
      end else if ((wb_src_d != WB_NONE) && (wb_addr_d != '0)) begin
         regs_q[wb_addr_d] <= wb_data_d;
      end
   end

   // Read ports, optionally forwarding the write being committed this cycle.
   always_comb begin
      rd_data_c = '0;
      rd_busy_c = '0;
      for (int i = 0; i < NRD; i++) begin
         rd_data_c[i*DATA_W +: DATA_W] = regs_q[bus.rd_addr[i*AW +: AW]];
         rd_busy_c[i]                  = pend[bus.rd_addr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
         if ((wb_src_d != WB_NONE) && (wb_addr_d != '0) &&
             (wb_addr_d == bus.rd_addr[i*AW +: AW])) begin
            rd_data_c[i*DATA_W +: DATA_W] = wb_data_d;
         end
         if (rsp_hit && (bus.ld_rsp_addr == bus.rd_addr[i*AW +: AW])) begin
            rd_busy_c[i] = 1'b0;
         end
`else
`endif
      end
   end

   assign bus.rd_data      = rd_data_c;
   assign bus.rd_busy      = rd_busy_c;
   assign bus.alu_wr_ready = alu_ready;
   assign bus.ld_iss_ready = iss_ready;
   assign bus.pend_cnt     = pend_cnt;
   assign bus.err          = err;

endmodule
